soc_system_speed_sense: RTL and testbench

// - Speed-feedback input peripheral on the lightweight HPS-to-FPGA Avalon-MM bus; counterpart of the speed-command output PIOs.
// - Decodes a quadrature wheel encoder (enc_a/enc_b).
// - Keeps a signed position count and a per-window signed step count (speed).
// - The HPS reads both back over an Avalon-MM slave with zero read wait states.

---
 rtl/soc_system_speed_sense_pkg.sv | 37 +++
 rtl/soc_system_quad_decoder.sv | 40 ++++
 rtl/soc_system_speed_sense.sv | 162 ++++++++++++++++
 tb/tb_soc_system_speed_sense.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_speed_sense_pkg.sv
// Shared constants and types for the quadrature speed-sense peripheral.
// Register map, CTRL bit positions and the signed encoder step type.

package soc_system_speed_sense_pkg;

  localparam logic [1:0] ADDR_SPEED    = 2'd0;
  localparam logic [1:0] ADDR_POSITION = 2'd1;
  localparam logic [1:0] ADDR_WINDOW   = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_NEW = 1;
  localparam int unsigned CTRL_ERR = 2;
  localparam int unsigned CTRL_IE  = 3;

  typedef logic signed [1:0] step_t;

  localparam step_t STEP_NONE = 2'b00;
  localparam step_t STEP_FWD  = 2'b01;
  localparam step_t STEP_REV  = 2'b11;

  // Gray sequence 00,01,11,10 maps to positions 0..3
  function automatic logic [1:0] gray_to_bin(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  function automatic step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] diff;
    diff = gray_to_bin(cur) - gray_to_bin(prev);
    case (diff)
      2'd1:    return STEP_FWD;
      2'd3:    return STEP_REV;
      default: return STEP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/soc_system_quad_decoder.sv
// Quadrature encoder front end: per-pin synchronizer and previous-state compare.
// Emits a signed step and an illegal-transition pulse each clock.

module soc_system_quad_decoder
  import soc_system_speed_sense_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  enc_a_i,
  input  logic  enc_b_i,
  output step_t step_o,
  output logic  err_o
);

  logic [SYNC_STAGES-1:0] sync_a_q;
  logic [SYNC_STAGES-1:0] sync_b_q;
  logic [1:0]             prev_q;
  logic [1:0]             cur;

  assign cur = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      prev_q   <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], enc_a_i};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], enc_b_i};
      prev_q   <= cur;
    end
  end

  // Both channels toggling at once means a missed state: no direction is knowable
  assign err_o  = ((prev_q ^ cur) == 2'b11);
  assign step_o = quad_step(prev_q, cur);

endmodule

// File: rtl/soc_system_speed_sense.sv
// Avalon-MM speed-feedback peripheral: quadrature position and per-window speed.
// Optional interrupt output and CTRL.IE bit are enabled by defining SPEED_SENSE_IRQ_EN.

module soc_system_speed_sense
  import soc_system_speed_sense_pkg::*;
#(
  parameter int unsigned WINDOW_DEFAULT = 1000,
  parameter int unsigned ACC_W          = 16,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic        enc_a,
  input  logic        enc_b,
`ifdef SPEED_SENSE_IRQ_EN
  output logic        irq,
`endif
  output logic [31:0] readdata
);

  localparam logic signed [ACC_W:0] SumMax = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SumMin = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic [31:0] WindowRst = 32'(WINDOW_DEFAULT);

  step_t step;
  logic  err_pulse;

  soc_system_quad_decoder #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_decoder (
    .clk     (clk),
    .reset_n (reset_n),
    .enc_a_i (enc_a),
    .enc_b_i (enc_b),
    .step_o  (step),
    .err_o   (err_pulse)
  );

  logic unused_read_n;
  assign unused_read_n = read_n;

  logic [31:0]             position_q, position_d;
  logic [31:0]             window_q, window_d;
  logic [31:0]             cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] speed_q, speed_d;
  logic                    en_q, en_d;
  logic                    new_q, new_d;
  logic                    err_q, err_d;
  logic                    ie_q, ie_d;
  logic                    irq_q;

  logic                    wr, wr_pos, wr_win, wr_ctrl;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] acc_sat;
  logic                    new_set;

  assign wr      = chipselect & ~write_n;
  assign wr_pos  = wr && (address == ADDR_POSITION);
  assign wr_win  = wr && (address == ADDR_WINDOW);
  assign wr_ctrl = wr && (address == ADDR_CTRL);

  // Accumulator never exceeds +/-max, so a single +/-1 overshoot is all we clamp
  always_comb begin
    acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-1){step[1]}}, step};
    if (acc_sum > SumMax) begin
      acc_sat = SumMax[ACC_W-1:0];
    end else if (acc_sum < SumMin) begin
      acc_sat = SumMin[ACC_W-1:0];
    end else begin
      acc_sat = acc_sum[ACC_W-1:0];
    end
  end

  always_comb begin
    position_d = wr_pos ? writedata : position_q + {{30{step[1]}}, step};
    window_d   = window_q;
    if (wr_win) begin
      window_d = (writedata < 32'd2) ? 32'd2 : writedata;
    end

    cnt_d   = cnt_q;
    acc_d   = acc_q;
    speed_d = speed_q;
    new_set = 1'b0;
    if (!en_q) begin
      cnt_d = window_q - 32'd1;
      acc_d = '0;
    end else if (cnt_q == 32'd0) begin
      speed_d = acc_sat;
      acc_d   = '0;
      new_set = 1'b1;
      cnt_d   = window_q - 32'd1;
    end else begin
      acc_d = acc_sat;
      cnt_d = cnt_q - 32'd1;
    end

    en_d  = wr_ctrl ? writedata[CTRL_EN] : en_q;
    new_d = new_set | (new_q & ~(wr_ctrl & writedata[CTRL_NEW]));
    err_d = err_pulse | (err_q & ~(wr_ctrl & writedata[CTRL_ERR]));
`ifdef SPEED_SENSE_IRQ_EN
    ie_d  = wr_ctrl ? writedata[CTRL_IE] : ie_q;
`else
    ie_d  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      position_q <= '0;
      window_q   <= WindowRst;
      cnt_q      <= WindowRst - 32'd1;
      acc_q      <= '0;
      speed_q    <= '0;
      en_q       <= 1'b0;
      new_q      <= 1'b0;
      err_q      <= 1'b0;
      ie_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      position_q <= position_d;
      window_q   <= window_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      speed_q    <= speed_d;
      en_q       <= en_d;
      new_q      <= new_d;
      err_q      <= err_d;
      ie_q       <= ie_d;
      irq_q      <= ie_q & new_q;
    end
  end

`ifdef SPEED_SENSE_IRQ_EN
  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_q;
`endif

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (address)
      ADDR_SPEED:    rdata = {{(32-ACC_W){speed_q[ACC_W-1]}}, speed_q};
      ADDR_POSITION: rdata = position_q;
      ADDR_WINDOW:   rdata = window_q;
      ADDR_CTRL:     rdata = {28'd0, ie_q, err_q, new_q, en_q};
      default:       rdata = '0;
    endcase
  end

  assign readdata = (chipselect && reset_n) ? rdata : 32'd0;

endmodule

// File: tb/tb_soc_system_speed_sense.sv
// Directed self-checking bench for soc_system_speed_sense (ACC_W=8 to reach saturation).
// Define SPEED_SENSE_IRQ_EN for the interrupt build.

module tb_soc_system_speed_sense;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        enc_a;
  logic        enc_b;
`ifdef SPEED_SENSE_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;
  int enc_idx  = 0;

  always #5 clk = ~clk;

  soc_system_speed_sense #(
    .WINDOW_DEFAULT (1000),
    .ACC_W          (8),
    .SYNC_STAGES    (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
`ifdef SPEED_SENSE_IRQ_EN
    .irq        (irq),
`endif
    .readdata   (readdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    #1;
    d          = readdata;
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check_eq(tag, d, exp);
  endtask

  // Gray order 00,01,11,10 is forward
  task automatic step_enc(input int dir);
    enc_idx = (enc_idx + dir) & 3;
    case (enc_idx)
      0:       {enc_a, enc_b} = 2'b00;
      1:       {enc_a, enc_b} = 2'b01;
      2:       {enc_a, enc_b} = 2'b11;
      default: {enc_a, enc_b} = 2'b10;
    endcase
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = '0;
    enc_a      = 1'b0;
    enc_b      = 1'b0;
    repeat (3) tick();
    read_check("rd_in_reset", 2'd2, 32'd0);
    reset_n = 1'b1;
    tick();

    read_check("rst_speed", 2'd0, 32'd0);
    read_check("rst_pos",   2'd1, 32'd0);
    read_check("rst_win",   2'd2, 32'd1000);
    read_check("rst_ctrl",  2'd3, 32'd0);
`ifdef SPEED_SENSE_IRQ_EN
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
`endif

    // Forward: 40 steps across one 1000-cycle window
    bus_write(2'd3, 32'h1);
    for (int i = 0; i < 40; i++) begin
      step_enc(1);
      repeat (25) tick();
    end
    read_check("fwd_speed", 2'd0, 32'd40);
    read_check("fwd_pos",   2'd1, 32'd40);
    read_check("fwd_ctrl",  2'd3, 32'h3);
    bus_write(2'd3, 32'h2);
    read_check("fwd_new_clr", 2'd3, 32'h0);

    // Reverse
    bus_write(2'd3, 32'h1);
    for (int i = 0; i < 40; i++) begin
      step_enc(-1);
      repeat (25) tick();
    end
    read_check("rev_speed", 2'd0, 32'hFFFF_FFD8);
    read_check("rev_pos",   2'd1, 32'd0);
    read_check("rev_ctrl",  2'd3, 32'h3);
    bus_write(2'd3, 32'h2);
    read_check("rev_new_clr", 2'd3, 32'h0);

    // Illegal 00 -> 11 jump
    {enc_a, enc_b} = 2'b11;
    repeat (5) tick();
    read_check("ill_pos",  2'd1, 32'd0);
    read_check("ill_ctrl", 2'd3, 32'h4);
    {enc_a, enc_b} = 2'b00;
    repeat (5) tick();
    read_check("ill_pos2", 2'd1, 32'd0);
    bus_write(2'd3, 32'h4);
    read_check("ill_err_clr", 2'd3, 32'h0);

    // Saturation: 200 steps in one window with ACC_W=8
    bus_write(2'd3, 32'h1);
    for (int i = 0; i < 200; i++) begin
      step_enc(1);
      repeat (4) tick();
    end
    repeat (201) tick();
    read_check("sat_speed", 2'd0, 32'd127);
    read_check("sat_pos",   2'd1, 32'd200);
    bus_write(2'd3, 32'h2);

    // POSITION write in the same cycle a step is applied: write wins
    step_enc(1);
    tick();
    tick();
    bus_write(2'd1, 32'h1234_5678);
    read_check("wr_step_same", 2'd1, 32'h1234_5678);
    repeat (5) tick();
    read_check("wr_step_hold", 2'd1, 32'h1234_5678);
    step_enc(1);
    repeat (4) tick();
    read_check("step_after_wr", 2'd1, 32'h1234_5679);

    // WINDOW clamp and readback
    bus_write(2'd2, 32'd0);
    read_check("win_min", 2'd2, 32'd2);
    bus_write(2'd2, 32'd32);
    read_check("win_32", 2'd2, 32'd32);

`ifdef SPEED_SENSE_IRQ_EN
    bus_write(2'd3, 32'h8);
    read_check("ie_rw", 2'd3, 32'h8);
    bus_write(2'd2, 32'd4);
    bus_write(2'd3, 32'h9);
    repeat (6) tick();
    check_eq("irq_set", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'hA);
    tick();
    check_eq("irq_clr", {31'd0, irq}, 32'd0);
    bus_write(2'd3, 32'h0);
    bus_write(2'd2, 32'd32);
`else
    bus_write(2'd3, 32'h8);
    read_check("ie_absent", 2'd3, 32'h0);
`endif

    // Short window, then reset mid-window
    bus_write(2'd3, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step_enc(1);
      repeat (2) tick();
    end
    repeat (34) tick();
    read_check("win32_speed", 2'd0, 32'd3);
    step_enc(1);
    repeat (5) tick();
    reset_n = 1'b0;
    {enc_a, enc_b} = 2'b00;
    enc_idx = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    read_check("mid_rst_speed", 2'd0, 32'd0);
    read_check("mid_rst_pos",   2'd1, 32'd0);
    read_check("mid_rst_win",   2'd2, 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
